q4a_rr_sched: RTL and testbench

//  Shares one registered z = (x^y)&x evaluation unit (equivalently x & ~y) between N_REQ requesters.
//  - Round-robin arbitration, one grant per cycle.
//  - Result returned with the requester ID under a valid/ready handshake.
//  - Sits between several stimulus sources and a single checker/consumer.
//

---
 rtl/q4a_rr_sched_pkg.sv | 12 +
 rtl/q4a_rr_sched_if.sv | 23 ++
 rtl/q4a_rr_sched_pick.sv | 27 ++
 rtl/q4a_rr_sched.sv | 86 ++++++++
 tb/tb_q4a_rr_sched.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/q4a_rr_sched_pkg.sv
// Shared types and helpers for the q4a round-robin evaluation scheduler.
package q4a_arb_pkg;

    typedef enum logic {S_EMPTY, S_FULL} q4a_state_t;

    localparam int N_REQ_DEF = 4;

    function automatic logic q4a_z(input logic x, input logic y);
        return x & ~y;
    endfunction

endpackage

// File: rtl/q4a_rr_sched_if.sv
// Requester/consumer bundle for q4a_rr_sched; lock exists only when Q4A_ARB_LOCK_EN is defined.
interface q4a_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] x;
    logic [N_REQ-1:0] y;
    logic [N_REQ-1:0] gnt;
    logic             z_valid;
    logic             z;
    logic [IDW-1:0]   z_id;
    logic             z_ready;
`ifdef Q4A_ARB_LOCK_EN
    logic [N_REQ-1:0] lock;

    modport master (output req, x, y, z_ready, lock, input gnt, z_valid, z, z_id);
    modport slave  (input req, x, y, z_ready, lock, output gnt, z_valid, z, z_id);
`else
    modport master (output req, x, y, z_ready, input gnt, z_valid, z, z_id);
    modport slave  (input req, x, y, z_ready, output gnt, z_valid, z, z_id);
`endif
endinterface

// File: rtl/q4a_rr_sched_pick.sv
// Rotating-priority encoder: first set req bit after ptr, wrapping modulo N_REQ.
module q4a_rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             any,
    output logic [IDW-1:0]   winner
);
    logic [IDW-1:0] idx;

    // Scan from the farthest slot back to ptr+1 so the nearest hit is written last.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/q4a_rr_sched.sv
// Round-robin sharing of one registered z = x & ~y unit between N_REQ requesters.
// Optional Q4A_ARB_LOCK_EN: lock input lets the last-granted requester keep the grant.
//
//   state   | meaning
//   S_EMPTY | no result held in the output register
//   S_FULL  | result held, waiting for z_ready
module q4a_rr_sched
    import q4a_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDW  = $clog2(N_REQ)
) (
    input logic           clk,
    input logic           areset,
    q4a_rr_sched_if.slave bus
);
    q4a_state_t       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             z_q, z_d;
    logic [IDW-1:0]   zid_q, zid_d;

    logic             pick_any;
    logic [IDW-1:0]   pick_w;
    logic             hold;
    logic             win_any;
    logic [IDW-1:0]   win;
    logic             ge;

    q4a_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_w)
    );

`ifdef Q4A_ARB_LOCK_EN
    assign hold = bus.req[ptr_q] & bus.lock[ptr_q];
`else
    assign hold = 1'b0;
`endif

    assign win_any = hold | pick_any;
    assign win     = hold ? ptr_q : pick_w;
    // Output register is free if empty or being drained on this same edge.
    assign ge      = (state_q == S_EMPTY) | bus.z_ready;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_EMPTY;
            ptr_q   <= IDW'(N_REQ - 1);
            gnt_q   <= '0;
            z_q     <= 1'b0;
            zid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            z_q     <= z_d;
            zid_q   <= zid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        z_d     = z_q;
        zid_d   = zid_q;
        if (ge && win_any) begin
            gnt_d   = N_REQ'(1) << win;
            ptr_d   = win;
            z_d     = q4a_z(bus.x[win], bus.y[win]);
            zid_d   = win;
            state_d = S_FULL;
        end else if ((state_q == S_FULL) && bus.z_ready) begin
            state_d = S_EMPTY;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.z_valid = (state_q == S_FULL);
    assign bus.z       = z_q;
    assign bus.z_id    = zid_q;

endmodule

// File: tb/tb_q4a_rr_sched.sv
// Directed vector bench for q4a_rr_sched (N_REQ=4), with or without Q4A_ARB_LOCK_EN.
module tb_q4a_rr_sched;

    logic clk;
    logic areset;
    int   n_tests = 0;
    int   n_fail  = 0;

    q4a_rr_sched_if #(.N_REQ(4)) bus ();

    q4a_rr_sched #(.N_REQ(4)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] x;
        logic [3:0] y;
        logic       zr;
        logic [3:0] gnt;
        logic       vld;
        logic       z;
        logic [1:0] zid;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic v,
                           input logic zz, input logic [1:0] id);
        chk({tag, " gnt"},     32'(bus.gnt),     32'(g));
        chk({tag, " z_valid"}, 32'(bus.z_valid), 32'(v));
        chk({tag, " z"},       32'(bus.z),       32'(zz));
        chk({tag, " z_id"},    32'(bus.z_id),    32'(id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_z;
        logic [3:0] exp_seq[6];

        // full contention, drain, backpressure, wrap/sparse, truth table, drain
        tbl[0]  = '{4'hF, 4'hF, 4'h5, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0};
        tbl[1]  = '{4'hF, 4'hF, 4'h5, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1};
        tbl[2]  = '{4'hF, 4'hF, 4'h5, 1'b1, 4'h4, 1'b1, 1'b0, 2'd2};
        tbl[3]  = '{4'hF, 4'hF, 4'h5, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3};
        tbl[4]  = '{4'hF, 4'hF, 4'h5, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{4'h0, 4'hF, 4'h5, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[6]  = '{4'h6, 4'hF, 4'h5, 1'b0, 4'h2, 1'b1, 1'b1, 2'd1};
        tbl[7]  = '{4'h6, 4'hF, 4'h5, 1'b0, 4'h0, 1'b1, 1'b1, 2'd1};
        tbl[8]  = '{4'h6, 4'hF, 4'h5, 1'b0, 4'h0, 1'b1, 1'b1, 2'd1};
        tbl[9]  = '{4'h6, 4'hF, 4'h5, 1'b0, 4'h0, 1'b1, 1'b1, 2'd1};
        tbl[10] = '{4'h6, 4'hF, 4'h5, 1'b1, 4'h4, 1'b1, 1'b0, 2'd2};
        tbl[11] = '{4'h8, 4'hF, 4'h5, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3};
        tbl[12] = '{4'h9, 4'hF, 4'h5, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0};
        tbl[13] = '{4'h8, 4'hF, 4'h5, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3};
        tbl[14] = '{4'h4, 4'h0, 4'h0, 1'b1, 4'h4, 1'b1, 1'b0, 2'd2};
        tbl[15] = '{4'h4, 4'h0, 4'h4, 1'b1, 4'h4, 1'b1, 1'b0, 2'd2};
        tbl[16] = '{4'h4, 4'h4, 4'h0, 1'b1, 4'h4, 1'b1, 1'b1, 2'd2};
        tbl[17] = '{4'h4, 4'h4, 4'h4, 1'b1, 4'h4, 1'b1, 1'b0, 2'd2};
        tbl[18] = '{4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd2};
        tbl[19] = '{4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd2};

        areset      = 1'b1;
        bus.req     = '0;
        bus.x       = '0;
        bus.y       = '0;
        bus.z_ready = 1'b0;
`ifdef Q4A_ARB_LOCK_EN
        bus.lock    = '0;
`endif
        #1;
        chk_out("reset", 4'h0, 1'b0, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            bus.req     = tbl[i].req;
            bus.x       = tbl[i].x;
            bus.y       = tbl[i].y;
            bus.z_ready = tbl[i].zr;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].vld, tbl[i].z, tbl[i].zid);
            if (i >= 14 && i <= 17) begin
                exp_z = (tbl[i].x[2] ^ tbl[i].y[2]) & tbl[i].x[2];
                chk($sformatf("vec%0d z model", i), 32'(bus.z), 32'(exp_z));
            end
        end

        // async reset while a result is stalled
        bus.req = 4'h2; bus.x = 4'h2; bus.y = 4'h0; bus.z_ready = 1'b0;
        step();
        chk_out("pre_rst grant", 4'h2, 1'b1, 1'b1, 2'd1);
        bus.req = 4'h0;
        step();
        chk_out("pre_rst stall", 4'h0, 1'b1, 1'b1, 2'd1);
        #2;
        areset = 1'b1;
        #1;
        chk_out("async_rst", 4'h0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        areset = 1'b0;
        bus.req = 4'h0; bus.z_ready = 1'b1;
        step();
        chk_out("post_rst idle", 4'h0, 1'b0, 1'b0, 2'd0);
        bus.req = 4'h3; bus.x = 4'h1; bus.y = 4'h0;
        step();
        chk_out("post_rst first", 4'h1, 1'b1, 1'b1, 2'd0);

        // lock hold vs plain alternation, starting with ptr at requester 0
`ifdef Q4A_ARB_LOCK_EN
        exp_seq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1};
        bus.lock = 4'h1;
`else
        exp_seq = '{4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1};
`endif
        for (int i = 0; i < 6; i++) begin
`ifdef Q4A_ARB_LOCK_EN
            if (i == 4) bus.lock = 4'h0;
`endif
            step();
            chk($sformatf("lock seq%0d gnt", i), 32'(bus.gnt), 32'(exp_seq[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
